// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer with a small return-address stack. Each cycle it
// advances the instruction address or applies jmp, call or ret. Every output
// is registered, so a command sampled at one edge is visible right after it.
//
// Optional feature macro: PC_SEQ_FAULT_EN
//   defined   : a call on a full stack or a ret on an empty stack sets the
//               sticky overflow/underflow flag and locks the core in FAULT.
//   undefined : a call on a full stack still jumps but drops the push; a ret
//               on an empty stack acts as a plain increment. The flags are
//               tied to 0 and FAULT is never entered.
//
// Parameters
//   INSTR_ADDR_SIZE  instruction address width (default 5)
//   STACK_DEPTH      return-address stack entries, 2..16 (default 4)
//
// Ports
//   clk         in   single clock, rising edge
//   rst         in   synchronous reset, active low
//   stall       in   hold every piece of state this cycle
//   halt        in   enter HALT (RUN only)
//   jmp         in   load jmp_addr
//   call        in   push instr_addr, then load jmp_addr
//   ret         in   pop, resume at popped address + 1
//   jmp_addr    in   target address for jmp/call
//   instr_addr  out  current instruction address
//   sp          out  stack occupancy 0..STACK_DEPTH
//   state       out  RUN=0, HALT=1, FAULT=2
//   overflow    out  sticky, call hit a full stack
//   underflow   out  sticky, ret hit an empty stack
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int INSTR_ADDR_SIZE = 5,
  parameter int STACK_DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       halt,
  input  logic                       jmp,
  input  logic                       call,
  input  logic                       ret,
  input  logic [INSTR_ADDR_SIZE-1:0] jmp_addr,
  output logic [INSTR_ADDR_SIZE-1:0] instr_addr,
  output logic [4:0]                 sp,
  output logic [1:0]                 state,
  output logic                       overflow,
  output logic                       underflow
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [4:0]                 DEPTH = 5'(STACK_DEPTH);
  localparam logic [INSTR_ADDR_SIZE-1:0] ONE   = INSTR_ADDR_SIZE'(1);

  state_t                     state_q, state_d;
  logic [INSTR_ADDR_SIZE-1:0] addr_q, addr_d;
  logic [4:0]                 sp_q, sp_d;
  logic [INSTR_ADDR_SIZE-1:0] stack_q [STACK_DEPTH];
  logic                       push_en;
  logic [4:0]                 sp_minus1;
  logic [INSTR_ADDR_SIZE-1:0] ret_addr;

`ifdef PC_SEQ_FAULT_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
`endif

  assign sp_minus1 = sp_q - 5'd1;

  // Top-of-stack read. The index is matched against the whole sp value so
  // no bits of sp go unused for depths that are not a power of two.
  always_comb begin
    ret_addr = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp_minus1 == 5'(i)) ret_addr = stack_q[i];
    end
  end

  // Next-state logic. stall and the non-RUN states simply keep the defaults;
  // in RUN the if/else chain encodes halt > jmp > call > ret > increment.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sp_d    = sp_q;
    push_en = 1'b0;
`ifdef PC_SEQ_FAULT_EN
    ovf_d   = ovf_q;
    unf_d   = unf_q;
`endif
    if (!stall) begin
      case (state_q)
        RUN: begin
          if (halt) begin
            state_d = HALT;
          end else if (jmp) begin
            addr_d = jmp_addr;
          end else if (call) begin
            if (sp_q < DEPTH) begin
              push_en = 1'b1;
              sp_d    = sp_q + 5'd1;
              addr_d  = jmp_addr;
            end else begin
`ifdef PC_SEQ_FAULT_EN
              ovf_d   = 1'b1;
              state_d = FAULT;
`else
              addr_d  = jmp_addr;
`endif
            end
          end else if (ret) begin
            if (sp_q != 5'd0) begin
              sp_d   = sp_minus1;
              addr_d = ret_addr + ONE;
            end else begin
`ifdef PC_SEQ_FAULT_EN
              unf_d   = 1'b1;
              state_d = FAULT;
`else
              addr_d  = addr_q + ONE;
`endif
            end
          end else begin
            addr_d = addr_q + ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Architectural registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      addr_q  <= '0;
      sp_q    <= '0;
`ifdef PC_SEQ_FAULT_EN
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sp_q    <= sp_d;
`ifdef PC_SEQ_FAULT_EN
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
`endif
    end
  end

  // Stack storage is never cleared; reset only has to block a same-cycle push.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (rst && push_en && (sp_q == 5'(i))) stack_q[i] <= addr_q;
    end
  end

  assign instr_addr = addr_q;
  assign sp         = sp_q;
  assign state      = state_q;
`ifdef PC_SEQ_FAULT_EN
  assign overflow   = ovf_q;
  assign underflow  = unf_q;
`else
  assign overflow   = 1'b0;
  assign underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer (default parameters). A behavioural
// model keeps the PC as an int and the return stack as a queue; each scenario
// task drives one cycle at a time and compares every output right after the
// edge. Works with or without PC_SEQ_FAULT_EN defined.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int VW    = AW + 5 + 2 + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stall = 1'b0, halt = 1'b0, jmp = 1'b0, call = 1'b0, ret = 1'b0;
  logic [AW-1:0] jmp_addr = '0;
  logic [AW-1:0] instr_addr;
  logic [4:0]    sp;
  logic [1:0]    state;
  logic          overflow, underflow;

  int nVectors = 0;
  int nMiscompares = 0;

  int mPc = 0;
  int mState = 0;
  bit mOv = 0, mUn = 0;
  int mStk[$];

  pc_sequencer #(.INSTR_ADDR_SIZE(AW), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt), .jmp(jmp),
    .call(call), .ret(ret), .jmp_addr(jmp_addr), .instr_addr(instr_addr),
    .sp(sp), .state(state), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: one architectural step from the specification's rules.
  task automatic modelStep(input bit r, st, h, j, c, rt, input int ja);
    if (!r) begin
      mPc = 0; mStk.delete(); mState = 0; mOv = 0; mUn = 0;
    end else if (st || mState != 0) begin
    end else if (h) begin
      mState = 1;
    end else if (j) begin
      mPc = ja;
    end else if (c) begin
      if (mStk.size() < DEPTH) begin
        mStk.push_back(mPc);
        mPc = ja;
      end else begin
`ifdef PC_SEQ_FAULT_EN
        mOv = 1; mState = 2;
`else
        mPc = ja;
`endif
      end
    end else if (rt) begin
      if (mStk.size() > 0) begin
        mPc = (mStk.pop_back() + 1) % (1 << AW);
      end else begin
`ifdef PC_SEQ_FAULT_EN
        mUn = 1; mState = 2;
`else
        mPc = (mPc + 1) % (1 << AW);
`endif
      end
    end else begin
      mPc = (mPc + 1) % (1 << AW);
    end
  endtask

  function automatic logic [VW-1:0] expVec();
    return {AW'(mPc), 5'(mStk.size()), 2'(mState), mOv, mUn};
  endfunction

  function automatic logic [VW-1:0] actVec();
    return {instr_addr, sp, state, overflow, underflow};
  endfunction

  // Drive one cycle of stimulus, advance the model at the edge, then settle.
  task automatic applyStimulus(input bit r, st, h, j, c, rt, input logic [AW-1:0] ja);
    rst = r; stall = st; halt = h; jmp = j; call = c; ret = rt; jmp_addr = ja;
    @(posedge clk);
    modelStep(r, st, h, j, c, rt, int'(ja));
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(0, 1, 1, 1, 1, 1, 5'd17);
    nVectors++;
    if (actVec() !== expVec()) begin
      nMiscompares++;
      $display("[TB] FAIL reset_vec: got %h expected %h", actVec(), expVec());
    end
    nVectors++;
    if ({instr_addr, sp, state, overflow, underflow} !== {5'd0, 5'd0, 2'd0, 1'b0, 1'b0}) begin
      nMiscompares++;
      $display("[TB] FAIL reset_const: got %h expected 0", actVec());
    end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 5'd0);
      nVectors++;
      if (actVec() !== expVec() || instr_addr !== 5'(i) || sp !== 5'd0 || state !== 2'd0) begin
        nMiscompares++;
        $display("[TB] FAIL seq_%0d: got %h expected %h (pc %0d)", i, actVec(), expVec(), i);
      end
    end
  endtask

  task automatic test_call_ret();
    applyStimulus(1, 0, 0, 0, 1, 0, 5'd20);
    nVectors++;
    if (actVec() !== expVec() || instr_addr !== 5'd20 || sp !== 5'd1) begin
      nMiscompares++;
      $display("[TB] FAIL call: got %h expected %h", actVec(), expVec());
    end
    applyStimulus(1, 0, 0, 0, 0, 1, 5'd0);
    nVectors++;
    if (actVec() !== expVec() || instr_addr !== 5'd4 || sp !== 5'd0) begin
      nMiscompares++;
      $display("[TB] FAIL ret: got %h expected %h", actVec(), expVec());
    end
  endtask

  task automatic test_priority();
    applyStimulus(1, 0, 0, 1, 1, 1, 5'd9);
    nVectors++;
    if (actVec() !== expVec() || instr_addr !== 5'd9 || sp !== 5'd0) begin
      nMiscompares++;
      $display("[TB] FAIL prio_jmp: got %h expected %h", actVec(), expVec());
    end
    applyStimulus(1, 1, 0, 1, 1, 1, 5'd22);
    nVectors++;
    if (actVec() !== expVec() || instr_addr !== 5'd9 || sp !== 5'd0) begin
      nMiscompares++;
      $display("[TB] FAIL prio_stall: got %h expected %h", actVec(), expVec());
    end
  endtask

  task automatic test_wrap_halt();
    applyStimulus(1, 0, 0, 1, 0, 0, 5'd31);
    applyStimulus(1, 0, 0, 0, 0, 0, 5'd0);
    nVectors++;
    if (actVec() !== expVec() || instr_addr !== 5'd0) begin
      nMiscompares++;
      $display("[TB] FAIL wrap: got %h expected %h", actVec(), expVec());
    end
    applyStimulus(1, 0, 1, 0, 0, 0, 5'd0);
    nVectors++;
    if (actVec() !== expVec() || state !== 2'd1 || instr_addr !== 5'd0) begin
      nMiscompares++;
      $display("[TB] FAIL halt_enter: got %h expected %h", actVec(), expVec());
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 0, 1, 1, 1, 5'($urandom_range(31)));
      nVectors++;
      if (actVec() !== expVec() || state !== 2'd1 || instr_addr !== 5'd0) begin
        nMiscompares++;
        $display("[TB] FAIL halt_hold_%0d: got %h expected %h", i, actVec(), expVec());
      end
    end
  endtask

  task automatic test_stack_limits();
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd0);
`ifdef PC_SEQ_FAULT_EN
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 1, 0, 5'(10 + i));
    nVectors++;
    if (actVec() !== expVec() || overflow !== 1'b1 || state !== 2'd2 || sp !== 5'd4) begin
      nMiscompares++;
      $display("[TB] FAIL overflow_fault: got %h expected %h", actVec(), expVec());
    end
    applyStimulus(1, 0, 0, 0, 0, 1, 5'd0);
    nVectors++;
    if (actVec() !== expVec() || state !== 2'd2) begin
      nMiscompares++;
      $display("[TB] FAIL fault_hold: got %h expected %h", actVec(), expVec());
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd0);
    nVectors++;
    if (actVec() !== expVec() || actVec() !== '0) begin
      nMiscompares++;
      $display("[TB] FAIL fault_reset: got %h expected %h", actVec(), expVec());
    end
    applyStimulus(1, 0, 0, 0, 0, 1, 5'd0);
    nVectors++;
    if (actVec() !== expVec() || underflow !== 1'b1 || state !== 2'd2) begin
      nMiscompares++;
      $display("[TB] FAIL underflow_fault: got %h expected %h", actVec(), expVec());
    end
`else
    applyStimulus(1, 0, 0, 1, 0, 0, 5'd7);
    applyStimulus(1, 0, 0, 0, 0, 1, 5'd0);
    nVectors++;
    if (actVec() !== expVec() || instr_addr !== 5'd8 || underflow !== 1'b0 || state !== 2'd0) begin
      nMiscompares++;
      $display("[TB] FAIL empty_ret: got %h expected %h", actVec(), expVec());
    end
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 1, 0, 5'(10 + i));
    nVectors++;
    if (actVec() !== expVec() || instr_addr !== 5'd14 || sp !== 5'd4 || overflow !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL full_call: got %h expected %h", actVec(), expVec());
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 1, 5'd0);
      nVectors++;
      if (actVec() !== expVec()) begin
        nMiscompares++;
        $display("[TB] FAIL unwind_%0d: got %h expected %h", i, actVec(), expVec());
      end
    end
`endif
  endtask

  task automatic test_random();
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd0);
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(99) >= 2), ($urandom_range(99) < 10),
                    ($urandom_range(99) < 2),  ($urandom_range(99) < 15),
                    ($urandom_range(99) < 25), ($urandom_range(99) < 25),
                    5'($urandom_range(31)));
      nVectors++;
      if (actVec() !== expVec()) begin
        nMiscompares++;
        $display("[TB] FAIL random_%0d: got %h expected %h", i, actVec(), expVec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_call_ret();
    test_priority();
    test_wrap_halt();
    test_stack_limits();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
